// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream width-down serializer.
// even_parity is only referenced when STREAM_SER_PARITY_EN is defined.
package stream_pkg;

  typedef enum logic [0:0] {
    SER_EMPTY = 1'b0,
    SER_SEND  = 1'b1
  } ser_state_e;

  localparam int unsigned ParityMaxW = 256;

  // Callers zero-extend the beat to ParityMaxW; zero bits do not affect XOR parity.
  function automatic logic even_parity(input logic [ParityMaxW-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/stream_serializer.sv
// Width-down converter: one IN_WIDTH word per input handshake, emitted LSB beat first.
// Optional even parity per beat on out_parity when STREAM_SER_PARITY_EN is defined.
module stream_serializer
  import stream_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 8,
  localparam int unsigned RATIO    = IN_WIDTH / OUT_WIDTH,
  localparam int unsigned CNT_W    = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [CNT_W-1:0]     in_last_beat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last
`ifdef STREAM_SER_PARITY_EN
  ,
  output logic                 out_parity
`endif
);

  localparam logic [CNT_W-1:0] MaxBeat = CNT_W'(RATIO - 1);

  if ((RATIO < 2) || ((IN_WIDTH % OUT_WIDTH) != 0)) begin : g_bad_params
    $fatal(1, "stream_serializer: IN_WIDTH must be a multiple of OUT_WIDTH with RATIO >= 2");
  end

  ser_state_e           state_q, state_d;
  logic [IN_WIDTH-1:0]  word_q, word_d;
  logic [CNT_W-1:0]     beat_q, beat_d;
  logic [CNT_W-1:0]     last_q, last_d;

  logic [CNT_W-1:0]     last_in;
  logic [OUT_WIDTH-1:0] beat_data;
  logic                 sending;
  logic                 beat_is_last;
  logic                 accept;

  // Only non-power-of-two ratios can present an out-of-range last-beat index.
  if ((1 << CNT_W) != RATIO) begin : g_clamp
    assign last_in = (in_last_beat > MaxBeat) ? MaxBeat : in_last_beat;
  end else begin : g_no_clamp
    assign last_in = in_last_beat;
  end

  always_comb begin
    beat_data = '0;
    for (int unsigned b = 0; b < RATIO; b++) begin
      if (beat_q == CNT_W'(b)) begin
        beat_data = word_q[b*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  assign sending      = (state_q == SER_SEND);
  assign beat_is_last = sending && (beat_q == last_q);

  // in_ready looks only at state and out_ready so it never forms a loop with in_valid.
  assign in_ready = !sending || (out_ready && beat_is_last);
  assign accept   = in_valid && in_ready;

  assign out_valid = sending;
  assign out_last  = beat_is_last;
  assign out_data  = sending ? beat_data : '0;

`ifdef STREAM_SER_PARITY_EN
  assign out_parity = even_parity(ParityMaxW'(out_data));
`endif

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    beat_d  = beat_q;
    last_d  = last_q;

    unique case (state_q)
      SER_EMPTY: begin
        if (in_valid) begin
          state_d = SER_SEND;
          word_d  = in_data;
          beat_d  = '0;
          last_d  = last_in;
        end
      end
      SER_SEND: begin
        if (out_ready) begin
          if (!beat_is_last) begin
            beat_d = beat_q + CNT_W'(1);
          end else if (accept) begin
            word_d = in_data;
            beat_d = '0;
            last_d = last_in;
          end else begin
            state_d = SER_EMPTY;
          end
        end
      end
      default: state_d = SER_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SER_EMPTY;
      word_q  <= '0;
      beat_q  <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_stream_serializer.sv
// Self-checking bench for stream_serializer: directed steps then random traffic
// against a beat-queue reference model.
module tb_stream_serializer;

  localparam int unsigned InW  = 32;
  localparam int unsigned OutW = 8;
  localparam int unsigned CntW = 2;

  typedef struct {
    logic [OutW-1:0] data;
    logic            last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [InW-1:0]  in_data = '0;
  logic [CntW-1:0] in_last_beat = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [OutW-1:0] out_data;
  logic            out_last;
`ifdef STREAM_SER_PARITY_EN
  logic            out_parity;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  beat_t q[$];

  stream_serializer #(
    .IN_WIDTH  (InW),
    .OUT_WIDTH (OutW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last_beat (in_last_beat),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last)
`ifdef STREAM_SER_PARITY_EN
    ,
    .out_parity   (out_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // A word of k+1 beats becomes k+1 queue entries, low byte first.
  task automatic push_word(input logic [InW-1:0] d, input int unsigned lb);
    beat_t b;
    for (int unsigned i = 0; i <= lb; i++) begin
      b.data = d[i*OutW +: OutW];
      b.last = (i == lb);
      q.push_back(b);
    end
  endtask

  task automatic cycle();
    logic exp_valid, exp_rdy, in_hs, out_hs;
    @(negedge clk);
    exp_valid = (q.size() != 0);
    exp_rdy   = !exp_valid || (out_ready && q[0].last);
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (exp_valid) begin
      check("out_data", 32'(out_data), 32'(q[0].data));
      check("out_last", 32'(out_last), 32'(q[0].last));
`ifdef STREAM_SER_PARITY_EN
      check("out_parity", 32'(out_parity), 32'(^q[0].data));
`endif
    end
    in_hs  = in_valid && exp_rdy;
    out_hs = exp_valid && out_ready;
    @(posedge clk);
    #1;
    if (out_hs) void'(q.pop_front());
    if (in_hs) push_word(in_data, int'(in_last_beat));
  endtask

  task automatic drive(input logic v, input logic [InW-1:0] d, input int unsigned lb,
                       input logic rdy);
    in_valid     = v;
    in_data      = d;
    in_last_beat = CntW'(lb);
    out_ready    = rdy;
    cycle();
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word, four beats
    drive(1'b1, 32'hDDCCBBAA, 3, 1'b1);
    check("latency_valid", 32'(out_valid), 32'd1);
    check("first_beat", 32'(out_data), 32'hAA);
    drive(1'b0, '0, 0, 1'b1);
    drive(1'b0, '0, 0, 1'b1);
    drive(1'b0, '0, 0, 1'b1);
    drive(1'b0, '0, 0, 1'b1);
    drive(1'b0, '0, 0, 1'b1);

    // Back-to-back words, no bubble
    drive(1'b1, 32'h03020100, 3, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h07060504, 3, 1'b1);
    drive(1'b1, 32'h07060504, 3, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 0, 1'b1);

    // Short words
    drive(1'b1, 32'h000000EE, 0, 1'b1);
    drive(1'b1, 32'h0000BEEF, 1, 1'b1);
    drive(1'b0, '0, 0, 1'b1);
    drive(1'b0, '0, 0, 1'b1);
    drive(1'b0, '0, 0, 1'b1);

    // Backpressure on beat 1, with a pending input word
    drive(1'b1, 32'h44332211, 3, 1'b1);
    drive(1'b0, '0, 0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h99887766, 2, 1'b0);
    check("stall_beat", 32'(out_data), 32'h22);
    for (int i = 0; i < 6; i++) drive(1'b0, '0, 0, 1'b1);

    // Mid-word reset during beat 2
    drive(1'b1, 32'hA3A2A1A0, 3, 1'b1);
    drive(1'b0, '0, 0, 1'b1);
    drive(1'b0, '0, 0, 1'b1);
    check("pre_reset_beat", 32'(out_data), 32'hA2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b0, '0, 0, 1'b1);
    drive(1'b1, 32'hB3B2B1B0, 3, 1'b1);
    check("post_reset_beat0", 32'(out_data), 32'hB0);
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 0, 1'b1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom % 4) != 0, $urandom, $urandom_range(0, 3), ($urandom % 10) < 7);
    end
    for (int i = 0; i < 8; i++) drive(1'b0, '0, 0, 1'b1);
    check("drained", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_serializer.md
# stream_serializer

Width-down converter that sits directly downstream of the pipeline register stage. It accepts one IN_WIDTH-bit word per valid/ready handshake and emits it as up to IN_WIDTH/OUT_WIDTH narrower beats on a valid/ready output, least-significant beat first. An end-of-word flag marks the final beat. It runs back-to-back with no bubble between consecutive words.

## Interface
- IN_WIDTH, default 32: input word width. It must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, default 8: output beat width. RATIO = IN_WIDTH/OUT_WIDTH must be ≥ 2; an elaboration-time assertion enforces this.
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  IN_WIDTH  upstream word.
- in_last_beat  input  CNT_W = $clog2(RATIO)  index of the final beat to emit (0 to RATIO-1). It is sampled with in_data.
- out_valid  output  1  beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  OUT_WIDTH  current beat.
- out_last  output  1  current beat is the final beat of the word.
- out_parity  output  1  present only with STREAM_SER_PARITY_EN.

## Operation
- **State machine:** two states, EMPTY and SEND. Held state is word_q, beat_q (CNT_W bits) and last_q (CNT_W bits).
- **EMPTY:**
  - in_ready = 1.
  - On in_valid: capture in_data and in_last_beat, set beat_q = 0, go to SEND.
- **SEND:**
  - Outputs: out_valid = 1, out_data = word_q[beat_q*OUT_WIDTH +: OUT_WIDTH], out_last = (beat_q == last_q).
- **Handshake in SEND:**
  - A handshake (out_valid && out_ready) with out_last = 0 increments beat_q.
  - A handshake with out_last = 1 ends the word:
    - if in_valid: capture the new word, beat_q = 0, stay in SEND;
    - otherwise: go to EMPTY.
- **in_ready rule:** in_ready = (state == EMPTY) || (out_ready && out_last). It is combinational from out_ready and depends on no input other than out_ready.
- **Clamping:** an in_last_beat value greater than RATIO-1 (possible when RATIO is not a power of two) is clamped to RATIO-1 at capture.
- **in_last_beat = 0:** a single-beat word; out_last is asserted on its only beat.
- **Unused high beats:** when last_q < RATIO-1, beats above last_q are never emitted.
- **Stall:** while out_valid && !out_ready, out_data, out_last and out_parity hold stable, and no word is accepted.
- **Beat counter:** beat_q never exceeds last_q, so no modular wrap is needed.

## Timing
- **Reset (while rst_n is low):** state = EMPTY, out_valid = 0, out_last = 0, out_data = 0, out_parity = 0, in_ready = 1. word_q, beat_q and last_q are cleared.
- **Reset mid-word:** the partially sent word is discarded. There is no output on the cycle after reset release.
- **Latency:** a word accepted on edge N presents beat 0 on out_* immediately after edge N. There is one cycle of latency from in_valid to out_valid.
- **Throughput:**
  - A word of k+1 beats occupies exactly k+1 output cycles when out_ready is held high.
  - Consecutive words have zero idle cycles between them.
  - Sustained input acceptance is one word per (last_beat+1) cycles.
- **Simultaneous events:** a final-beat handshake and an input handshake in the same cycle is the normal back-to-back case. The new word's beat 0 appears on the next cycle.

## Configuration
- Macro: STREAM_SER_PARITY_EN.
- **Defined:**
  - out_parity port exists and equals ^out_data (even parity over the current beat).
  - It is combinational from the registered beat and stable under stall.
- **Undefined:** the out_parity port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package stream_pkg holds:
  - the state enum typedef ser_state_e {SER_EMPTY, SER_SEND};
  - the parity function used under STREAM_SER_PARITY_EN.
- CNT_W and RATIO are module localparams derived from the parameters.
- No sub-module: a single flat module with beat mux, counter and FSM.

## Test plan
- **Single word, out_ready=1:** in_data=32'hDDCCBBAA, in_last_beat=3 → beats AA, BB, CC, DD on four consecutive cycles; out_last only on DD; in_ready high again in the DD cycle.
- **Back-to-back:** words 32'h03020100 and 32'h07060504, in_valid held high → eight contiguous beats 00 through 07 with no gap; second word accepted in the cycle 03 is consumed.
- **Short words:** in_last_beat=0 with 32'h000000EE → one beat EE with out_last=1. in_last_beat=1 with 32'h0000BEEF → EF, BE.
- **Backpressure:** out_ready low for 3 cycles on beat 1 → out_data, out_last and out_valid stable; in_ready=0; sequence resumes unchanged.
- **Mid-word reset:** assert rst_n low during beat 2 → out_valid=0 and in_ready=1 at once; after release, the next word starts at beat 0.
- **Parity (macro defined):** beat 8'h07 → out_parity=1; beat 8'h03 → out_parity=0.
